// File: rtl/flag_ctrl.sv
// Condition-code register controller for the EX stage.
// Maintains the {C,N,Z} flags from ALU results, SETC/CLRC and taken jumps,
// and sequences a single-entry CCR save/restore around interrupt entry and RTI.
module flag_ctrl #(
  parameter int W          = 16,
  parameter int SAVE_DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  input  logic         stall,
  input  logic [3:0]   alu_operation,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         setc,
  input  logic         clrc,
  input  logic         jz_taken,
  input  logic         jn_taken,
  input  logic         jc_taken,
  input  logic         int_req,
  input  logic         rti,
  output logic [2:0]   ccr,
  output logic         int_ack,
  output logic         in_isr
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ACK     = 2'd1,
    S_ISR     = 2'd2,
    S_RESTORE = 2'd3
  } state_e;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  state_e                  state_q, state_d;
  logic [2:0]              ccr_q, ccr_d;
  logic [SAVE_DEPTH*3-1:0] shadow_q, shadow_d;
  logic                    int_ack_q, int_ack_d;
  logic                    in_isr_q, in_isr_d;

  logic upd_zn;
  logic upd_c;
  logic issue;

  // An EX instruction only affects flags when it is valid and the pipe moves.
  assign issue = ex_valid & ~stall;

  // Decode which flags the current ALU opcode is allowed to write.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
    upd_zn = 1'b0;
    upd_c  = 1'b0;
    unique case (alu_operation)
      4'b0100, 4'b0110, 4'b1001, 4'b1010, 4'b1011: upd_zn = 1'b1;
      4'b0101, 4'b1000, 4'b1100, 4'b1101: begin
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next CCR value: restore beats ALU, ALU beats setc/clrc, those beat jump clears.
  always_comb begin
    ccr_d = ccr_q;
    if (issue) begin
      if (upd_zn)        ccr_d[CCR_Z] = (alu_result == '0);
      else if (jz_taken) ccr_d[CCR_Z] = 1'b0;

      if (upd_zn)        ccr_d[CCR_N] = alu_result[W-1];
      else if (jn_taken) ccr_d[CCR_N] = 1'b0;

      if (upd_c)         ccr_d[CCR_C] = alu_carry;
      else if (clrc)     ccr_d[CCR_C] = 1'b0;
      else if (setc)     ccr_d[CCR_C] = 1'b1;
      else if (jc_taken) ccr_d[CCR_C] = 1'b0;
    end
    if (state_q == S_RESTORE && !stall) ccr_d = shadow_q[2:0];
  end

  // Interrupt sequencing: accept, save the post-update CCR, service, restore.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    int_ack_d = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (int_req && !stall) state_d = S_ACK;
      end
      S_ACK: begin
        if (!stall) begin
          shadow_d[2:0] = ccr_d;
          int_ack_d     = 1'b1;
          state_d       = S_ISR;
        end
      end
      S_ISR: begin
        if (rti && issue) state_d = S_RESTORE;
      end
      S_RESTORE: begin
        if (!stall) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    in_isr_d = (state_d == S_ISR) || (state_d == S_RESTORE);
  end

  // State, flags, shadow and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      ccr_q     <= '0;
      // NOTE: the shadow is reset with everything else, so an interrupted ISR leaves no stale saved flags behind.
      shadow_q  <= '0;
      int_ack_q <= 1'b0;
      in_isr_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      ccr_q     <= ccr_d;
      shadow_q  <= shadow_d;
      int_ack_q <= int_ack_d;
      in_isr_q  <= in_isr_d;
    end
  end

  assign ccr     = ccr_q;
  assign int_ack = int_ack_q;
  assign in_isr  = in_isr_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Self-checking bench for flag_ctrl: directed scenarios with fixed expected
// values, then randomized traffic compared against a rule-level model.
module tb_flag_ctrl;

  localparam int W = 16;

  localparam logic [3:0] OP_UNUSED0 = 4'b0000;
  localparam logic [3:0] OP_NOP     = 4'b0011;
  localparam logic [3:0] OP_NOT     = 4'b0100;
  localparam logic [3:0] OP_INC     = 4'b0101;
  localparam logic [3:0] OP_DEC     = 4'b0110;
  localparam logic [3:0] OP_MOV     = 4'b0111;
  localparam logic [3:0] OP_ADD     = 4'b1000;
  localparam logic [3:0] OP_SUB     = 4'b1001;
  localparam logic [3:0] OP_AND     = 4'b1010;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ex_valid, stall, alu_carry, setc, clrc;
  logic         jz_taken, jn_taken, jc_taken, int_req, rti;
  logic [3:0]   alu_operation;
  logic [W-1:0] alu_result;
  logic [2:0]   ccr;
  logic         int_ack, in_isr;

  flag_ctrl #(.W(W), .SAVE_DEPTH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .stall        (stall),
    .alu_operation(alu_operation),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .setc         (setc),
    .clrc         (clrc),
    .jz_taken     (jz_taken),
    .jn_taken     (jn_taken),
    .jc_taken     (jc_taken),
    .int_req      (int_req),
    .rti          (rti),
    .ccr          (ccr),
    .int_ack      (int_ack),
    .in_isr       (in_isr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: interrupt phase as a plain integer, flags as bits {C,N,Z}.
  localparam int M_RUN = 0, M_ACK = 1, M_ISR = 2, M_RESTORE = 3;
  bit [2:0] m_ccr, m_shadow;
  int       m_mode;
  bit       m_ack, m_isr;

  task automatic model_reset();
    m_ccr = 3'b000; m_shadow = 3'b000; m_mode = M_RUN; m_ack = 1'b0; m_isr = 1'b0;
  endtask

  // 0: no flags, 1: Z and N, 2: Z, N and C
  function automatic int op_class(input logic [3:0] op);
    case (op)
      OP_NOT, OP_DEC, OP_SUB, OP_AND, 4'b1011: return 1;
      OP_INC, OP_ADD, 4'b1100, 4'b1101:        return 2;
      default:                                  return 0;
    endcase
  endfunction

  // Apply writers lowest priority first so higher-priority writers overwrite.
  task automatic model_step();
    bit       go  = !stall;
    bit       ex  = ex_valid && !stall;
    bit [2:0] nxt = m_ccr;
    int       cls = op_class(alu_operation);
    if (ex) begin
      if (jz_taken) nxt[0] = 1'b0;
      if (jn_taken) nxt[1] = 1'b0;
      if (jc_taken) nxt[2] = 1'b0;
      if (setc)     nxt[2] = 1'b1;
      if (clrc)     nxt[2] = 1'b0;
      if (cls >= 1) begin
        nxt[0] = (alu_result == 0);
        nxt[1] = ($signed(alu_result) < 0);
      end
      if (cls == 2) nxt[2] = alu_carry;
    end
    if (m_mode == M_RESTORE && go) nxt = m_shadow;
    m_ack = 1'b0;
    case (m_mode)
      M_RUN:     if (int_req && go) m_mode = M_ACK;
      M_ACK:     if (go) begin m_shadow = nxt; m_ack = 1'b1; m_mode = M_ISR; end
      M_ISR:     if (rti && ex) m_mode = M_RESTORE;
      M_RESTORE: if (go) m_mode = M_RUN;
      default:   m_mode = M_RUN;
    endcase
    m_ccr = nxt;
    m_isr = (m_mode == M_ISR) || (m_mode == M_RESTORE);
  endtask

  task automatic idle();
    ex_valid = 1'b0; stall = 1'b0; alu_operation = OP_NOP; alu_result = '0;
    alu_carry = 1'b0; setc = 1'b0; clrc = 1'b0; jz_taken = 1'b0;
    jn_taken = 1'b0; jc_taken = 1'b0; int_req = 1'b0; rti = 1'b0;
  endtask

  task automatic op(input logic [3:0] opc, input logic [W-1:0] res, input logic cy);
    ex_valid = 1'b1; alu_operation = opc; alu_result = res; alu_carry = cy;
  endtask

  // One clock: advance the model, clock the DUT, compare all outputs.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".ccr"},     {29'd0, ccr},     {29'd0, m_ccr});
    check({tag, ".int_ack"}, {31'd0, int_ack}, {31'd0, m_ack});
    check({tag, ".in_isr"},  {31'd0, in_isr},  {31'd0, m_isr});
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check("rst_ccr", {29'd0, ccr}, 32'd0);
    check("rst_ack", {31'd0, int_ack}, 32'd0);
    check("rst_isr", {31'd0, in_isr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Z/N/C update and opcode mask
    idle(); op(OP_ADD, 16'h0000, 1'b1); cycle("add0");  check("add0_ccr", {29'd0, ccr}, 32'b101);
    idle(); op(OP_SUB, 16'h8001, 1'b0); cycle("sub");   check("sub_ccr",  {29'd0, ccr}, 32'b110);
    idle(); op(OP_ADD, 16'h0001, 1'b0); cycle("add1");  check("add1_ccr", {29'd0, ccr}, 32'b000);
    idle(); op(OP_MOV, 16'h0000, 1'b1); cycle("mov");   check("mov_ccr",  {29'd0, ccr}, 32'b000);
    idle(); op(OP_UNUSED0, 16'h0000, 1'b1); cycle("unused"); check("unused_ccr", {29'd0, ccr}, 32'b000);
    idle(); op(OP_INC, 16'h0000, 1'b1); cycle("inc");   check("inc_ccr",  {29'd0, ccr}, 32'b101);
    idle(); op(OP_DEC, 16'hFFFF, 1'b0); cycle("dec");   check("dec_ccr",  {29'd0, ccr}, 32'b110);

    // Priorities
    idle(); op(OP_NOP, 0, 0); jc_taken = 1; setc = 1; cycle("jc_setc"); check("jc_setc_ccr", {29'd0, ccr}, 32'b110);
    idle(); op(OP_NOP, 0, 0); jc_taken = 1;           cycle("jc");      check("jc_ccr",      {29'd0, ccr}, 32'b010);
    idle(); op(OP_NOP, 0, 0); jn_taken = 1;           cycle("jn");      check("jn_ccr",      {29'd0, ccr}, 32'b000);
    idle(); op(OP_ADD, 16'h0000, 1'b0);               cycle("addz");    check("addz_ccr",    {29'd0, ccr}, 32'b001);
    idle(); op(OP_SUB, 16'h0000, 1'b0); jz_taken = 1; cycle("alu_jz");  check("alu_jz_ccr",  {29'd0, ccr}, 32'b001);
    idle(); op(OP_NOP, 0, 0); jz_taken = 1;           cycle("jz");      check("jz_ccr",      {29'd0, ccr}, 32'b000);
    idle(); op(OP_NOP, 0, 0); setc = 1; clrc = 1;     cycle("setclr");  check("setclr_ccr",  {29'd0, ccr}, 32'b000);
    idle(); op(OP_NOP, 0, 0); setc = 1;               cycle("setc");    check("setc_ccr",    {29'd0, ccr}, 32'b100);
    idle(); op(OP_NOP, 0, 0); clrc = 1;               cycle("clrc");    check("clrc_ccr",    {29'd0, ccr}, 32'b000);
    idle(); op(OP_ADD, 16'h0005, 1'b1); clrc = 1;     cycle("alu_clrc"); check("alu_clrc_ccr", {29'd0, ccr}, 32'b100);
    idle(); op(OP_ADD, 16'h0000, 1'b0); stall = 1;    cycle("stall");   check("stall_ccr",   {29'd0, ccr}, 32'b100);
    idle(); op(OP_ADD, 16'h0000, 1'b0); ex_valid = 0; cycle("novalid"); check("novalid_ccr", {29'd0, ccr}, 32'b100);

    // Interrupt entry, ISR updates, restore
    idle(); op(OP_ADD, 16'h0000, 1'b1); cycle("pre_int"); check("pre_int_ccr", {29'd0, ccr}, 32'b101);
    idle(); int_req = 1; cycle("req");   check("req_ack", {31'd0, int_ack}, 32'd0);
    idle(); cycle("ack");                check("ack_pulse", {31'd0, int_ack}, 32'd1);
                                         check("ack_isr",   {31'd0, in_isr},  32'd1);
    idle(); cycle("isr0");               check("isr0_ack",  {31'd0, int_ack}, 32'd0);
    idle(); op(OP_AND, 16'h8000, 1'b0); cycle("isr_and"); check("isr_and_ccr", {29'd0, ccr}, 32'b110);
    idle(); op(OP_NOP, 0, 0); clrc = 1; cycle("isr_clrc"); check("isr_clrc_ccr", {29'd0, ccr}, 32'b010);
    for (int i = 0; i < 3; i++) begin
      idle(); int_req = 1; cycle("nest"); check("nest_ack", {31'd0, int_ack}, 32'd0);
    end
    idle(); op(OP_NOP, 0, 0); rti = 1; cycle("rti");  check("rti_isr", {31'd0, in_isr}, 32'd1);
                                                      check("rti_ccr", {29'd0, ccr}, 32'b010);
    idle(); op(OP_ADD, 16'h1234, 1'b0); cycle("restore"); check("restore_ccr", {29'd0, ccr}, 32'b101);
                                                          check("restore_isr", {31'd0, in_isr}, 32'd0);
    idle(); op(OP_NOP, 0, 0); rti = 1; cycle("rti_run"); check("rti_run_ccr", {29'd0, ccr}, 32'b101);

    // Stall held in ACK, then held int_req re-triggers only after RESTORE
    idle(); int_req = 1; cycle("req2");
    for (int i = 0; i < 3; i++) begin
      idle(); op(OP_ADD, 16'h0000, 1'b0); stall = 1; int_req = 1; cycle("ack_stall");
      check("ack_stall_ack", {31'd0, int_ack}, 32'd0);
      check("ack_stall_ccr", {29'd0, ccr}, 32'b101);
    end
    idle(); int_req = 1; op(OP_ADD, 16'h8000, 1'b0); cycle("ack_rel");
    check("ack_rel_ack", {31'd0, int_ack}, 32'd1);
    check("ack_rel_ccr", {29'd0, ccr}, 32'b010);
    idle(); int_req = 1; op(OP_SUB, 16'h0000, 1'b0); cycle("isr2_sub"); check("isr2_sub_ccr", {29'd0, ccr}, 32'b001);
    idle(); int_req = 1; op(OP_NOP, 0, 0); rti = 1; cycle("rti2");
    idle(); int_req = 1; cycle("restore2"); check("restore2_ccr", {29'd0, ccr}, 32'b010);
                                            check("restore2_isr", {31'd0, in_isr}, 32'd0);
    idle(); int_req = 1; cycle("retrig_req"); check("retrig_req_ack", {31'd0, int_ack}, 32'd0);
    idle(); cycle("retrig_ack"); check("retrig_ack", {31'd0, int_ack}, 32'd1);

    // Asynchronous reset in the middle of the ISR, no clock edge involved
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_ccr", {29'd0, ccr},     32'd0);
    check("arst_isr", {31'd0, in_isr},  32'd0);
    check("arst_ack", {31'd0, int_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      idle();
      ex_valid      = ($urandom_range(3) != 0);
      stall         = ($urandom_range(4) == 0);
      alu_operation = 4'($urandom_range(15));
      case ($urandom_range(3))
        0:       alu_result = 16'h0000;
        1:       alu_result = 16'hFFFF;
        default: alu_result = 16'($urandom);
      endcase
      alu_carry = 1'($urandom_range(1));
      setc      = ($urandom_range(3) == 0);
      clrc      = ($urandom_range(3) == 0);
      jz_taken  = ($urandom_range(3) == 0);
      jn_taken  = ($urandom_range(3) == 0);
      jc_taken  = ($urandom_range(3) == 0);
      int_req   = ($urandom_range(7) == 0);
      rti       = ($urandom_range(5) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
